multicycle_adder: RTL and testbench

- Parametrised, chunk-serial successor of the gate-level HA cell: a WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
- Ripples the carry through a registered carry flop between chunks.
- Trades latency for area; it is the shared ALU-side adder for the multicycle MIPS datapath.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.

---
 rtl/multicycle_adder_pkg.sv | 21 ++
 rtl/multicycle_adder_if.sv | 29 ++
 rtl/multicycle_adder_chunk_adder.sv | 38 +++
 rtl/multicycle_adder.sv | 126 ++++++++++++
 tb/tb_multicycle_adder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the chunk-serial multicycle adder.
// Contents:
//   state_t   - sequencer state (IDLE / RUN)
//   idx_width - width of the chunk index counter: clog2(n), never below 1
package adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index counter width; a single-chunk build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle of the multicycle adder.
// Signals:
//   start, Sub, A, B, Cin - request side (driven by the master)
//   busy, done, Su, Co, Ov - status/result side (driven by the adder)
// Modports: master (requester), slave (the adder itself).
interface multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Su;
    logic             Co;
    logic             Ov;

    modport master (
        output start, Sub, A, B, Cin,
        input  busy, done, Su, Co, Ov
    );

    modport slave (
        input  start, Sub, A, B, Cin,
        output busy, done, Su, Co, Ov
    );
endinterface

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells, each cell
// being a pair of half adders plus an OR of their carries.
// Ports:
//   a, b     - chunk operands
//   ci       - carry into bit 0
//   s        - chunk sum
//   co       - carry out of the top bit
//   c_msb_in - carry into the top bit (needed for signed overflow)
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [CHUNK:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic hs1_s;
        logic hc1_s;
        logic hc2_s;
        // First half adder: a + b
        assign hs1_s = a[i] ^ b[i];
        assign hc1_s = a[i] & b[i];
        // Second half adder: partial sum + incoming carry
        assign s[i]     = hs1_s ^ c_s[i];
        assign hc2_s    = hs1_s & c_s[i];
        assign c_s[i+1] = hc1_s | hc2_s;
    end

    assign co       = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// Chunk-serial WIDTH-bit adder/subtractor: CHUNK bits per clock, carry held
// in a register between chunks. A start in IDLE captures operands (B is
// inverted and the carry forced to 1 for subtraction); NCHUNK RUN cycles
// later done pulses for one cycle together with Su/Co/Ov.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (aborts any operation, no done)
//   bus - slave side of multicycle_adder_if
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_adder_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   k_q, k_d;
    logic [WIDTH-1:0]  su_q, su_d;
    logic              co_q, co_d;
    logic              ov_q, ov_d;
    logic              done_q, done_d;

    int                base_s;
    logic [CHUNK-1:0]  sum_s;
    logic              cout_s;
    logic              cmsb_s;

    assign base_s = int'(k_q) * CHUNK;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a        (opa_q[base_s +: CHUNK]),
        .b        (opb_q[base_s +: CHUNK]),
        .ci       (carry_q),
        .s        (sum_s),
        .co       (cout_s),
        .c_msb_in (cmsb_s)
    );

    // Next-state: operand capture on start, one chunk per RUN cycle.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        k_d     = k_q;
        su_d    = su_q;
        co_d    = co_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    opa_d   = bus.A;
                    opb_d   = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Sub ? 1'b1 : bus.Cin;
                    k_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                su_d[base_s +: CHUNK] = sum_s;
                carry_d = cout_s;
                if (k_q == LAST_IDX) begin
                    co_d    = cout_s;
                    ov_d    = cmsb_s ^ cout_s;
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + IDXW'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            su_q    <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            su_q    <= su_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.Su   = su_q;
    assign bus.Co   = co_q;
    assign bus.Ov   = ov_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed testbench for multicycle_adder (WIDTH=32, CHUNK=8, four cycles per op).
module tb_multicycle_adder;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

    multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; no checking here.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          output logic [31:0] su, output logic co, output logic ov,
                          output int lat, output int busy_cnt);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while ((bus.done !== 1'b1) && (lat < 20)) begin
            tick();
            lat++;
            if ((bus.busy === 1'b1) && (bus.done !== 1'b1)) busy_cnt++;
        end
        su = bus.Su; co = bus.Co; ov = bus.Ov;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus.busy, bus.done, bus.Co, bus.Ov} !== 4'b0000)
            $display("FAIL reset_flags busy/done/co/ov=%b expected 0000", {bus.busy, bus.done, bus.Co, bus.Ov});
        else pass_cnt++;
        total_cnt++;
        if (bus.Su !== 32'h0000_0000) $display("FAIL reset_su got %h expected 00000000", bus.Su);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_basic();
        logic [31:0] su; logic co, ov; int lat, bc;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if (lat !== 4) $display("FAIL add_latency got %0d expected 4", lat); else pass_cnt++;
        total_cnt++;
        if (bc !== 4) $display("FAIL add_busy_cycles got %0d expected 4", bc); else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL add_busy_at_done got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++;
        if ({su, co, ov} !== {32'h0000_0100, 1'b0, 1'b0})
            $display("FAIL add_basic got su=%h co=%b ov=%b expected su=00000100 co=0 ov=0", su, co, ov);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL done_one_cycle got %b expected 0", bus.done); else pass_cnt++;
    endtask

    task automatic test_carry_overflow();
        logic [31:0] su; logic co, ov; int lat, bc;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if ({su, co, ov} !== {32'h0000_0000, 1'b1, 1'b0})
            $display("FAIL carry_wrap got su=%h co=%b ov=%b expected su=00000000 co=1 ov=0", su, co, ov);
        else pass_cnt++;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if ({su, co, ov} !== {32'h8000_0000, 1'b0, 1'b1})
            $display("FAIL signed_ovf got su=%h co=%b ov=%b expected su=80000000 co=0 ov=1", su, co, ov);
        else pass_cnt++;
        run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if ({su, co, ov} !== {32'h0000_0031, 1'b0, 1'b0})
            $display("FAIL add_cin got su=%h co=%b ov=%b expected su=00000031 co=0 ov=0", su, co, ov);
        else pass_cnt++;
    endtask

    task automatic test_subtract();
        logic [31:0] su; logic co, ov; int lat, bc;
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, su, co, ov, lat, bc);
        total_cnt++;
        if ({su, co, ov} !== {32'hFFFF_FFFE, 1'b0, 1'b0})
            $display("FAIL sub_borrow got su=%h co=%b ov=%b expected su=fffffffe co=0 ov=0", su, co, ov);
        else pass_cnt++;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, su, co, ov, lat, bc);
        total_cnt++;
        if ({su, co, ov} !== {32'h7FFF_FFFF, 1'b1, 1'b1})
            $display("FAIL sub_ovf got su=%h co=%b ov=%b expected su=7fffffff co=1 ov=1", su, co, ov);
        else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int lat;
        bus.A = 32'd3; bus.B = 32'd4; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.A = 32'd0; bus.B = 32'd0; bus.Sub = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.Sub = 1'b0;
        lat = 2;
        while ((bus.done !== 1'b1) && (lat < 20)) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat !== 4) $display("FAIL ignore_latency got %0d expected 4", lat); else pass_cnt++;
        total_cnt++;
        if (bus.Su !== 32'd7) $display("FAIL ignore_start got %h expected 00000007", bus.Su); else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL ignore_no_restart busy=%b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] su; logic co, ov; int lat, bc;
        run_op(32'd3, 32'd4, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if (su !== 32'd7) $display("FAIL b2b_first got %h expected 00000007", su); else pass_cnt++;
        // Still in the done cycle: launch the next op immediately.
        run_op(32'd10, 32'd20, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if (lat !== 4) $display("FAIL b2b_latency got %0d expected 4", lat); else pass_cnt++;
        total_cnt++;
        if (su !== 32'd30) $display("FAIL b2b_second got %h expected 0000001e", su); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] su; logic co, ov; int lat, bc, dones;
        bus.A = 32'd1; bus.B = 32'd1; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.done, bus.Co, bus.Ov} !== 4'b0000)
            $display("FAIL midrst_flags busy/done/co/ov=%b expected 0000", {bus.busy, bus.done, bus.Co, bus.Ov});
        else pass_cnt++;
        total_cnt++;
        if (bus.Su !== 32'd0) $display("FAIL midrst_su got %h expected 00000000", bus.Su); else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL midrst_no_done got %0d pulses expected 0", dones); else pass_cnt++;
        run_op(32'd2, 32'd2, 1'b0, 1'b0, su, co, ov, lat, bc);
        total_cnt++;
        if ((su !== 32'd4) || (lat !== 4))
            $display("FAIL after_rst_op got su=%h lat=%0d expected su=00000004 lat=4", su, lat);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.Sub = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        test_reset();
        test_add_basic();
        test_carry_overflow();
        test_subtract();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
